// File: rtl/mac_accumulator.sv
// Dot-product accumulator behind the 8-bit array multiplier. It sums len unsigned
// products into a wrapping ACC_W-bit register and presents the sum over valid/ready.
module mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   count;
  logic [ACC_W:0]     sum_ext;

  // One extra bit on the adder exposes the carry out of ACC_W for the sticky flag.
  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W - PROD_W + 1){1'b0}}, prod};
  end

  assign prod_ready = (state == ACCUM);
  assign res_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            overflow <= 1'b0;
            if (len != '0) begin
              count <= len;
              state <= ACCUM;
            end else begin
              result <= '0;
              state  <= DONE;
            end
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc      <= sum_ext[ACC_W-1:0];
            overflow <= overflow | sum_ext[ACC_W];
            count    <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              result <= sum_ext[ACC_W-1:0];
              state  <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequential stage directly downstream of the 8-bit array multiplier.
- Consumes a stream of 16-bit products over a valid/ready handshake.
- Sums a programmed number of terms (vector dot product) into a wide accumulator.
- Presents the sum with a valid/ready result handshake and a sticky overflow flag.

Parameters:
PROD_W, 16, width of incoming product (multiplier output width)
ACC_W, 24, accumulator/result width; must be >= PROD_W
LEN_W, 8, width of term-count field

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin new accumulation; sampled only in IDLE
len  input  LEN_W  number of products to sum; sampled with start
prod_valid  input  1  product word valid
prod  input  PROD_W  unsigned product from multiplier
prod_ready  output  1  block accepts product this cycle
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
result  output  ACC_W  accumulated sum, modulo 2^ACC_W
overflow  output  1  sticky: a carry out of ACC_W occurred during this accumulation
busy  output  1  state != IDLE

Behaviour:
- Reset (async, immediate, any state): state=IDLE; acc, count, result=0; res_valid, prod_ready, overflow, busy=0.
- FSM states: IDLE, ACCUM, DONE. All transitions occur on rising clk.
- IDLE:
  - prod_ready=0; res_valid=0; prod_valid ignored.
  - start=1 and len!=0: latch count=len; clear acc and overflow; go to ACCUM.
  - start=1 and len==0: acc=0, overflow=0; go to DONE. result=0 is valid the next cycle.
- ACCUM:
  - prod_ready=1 (combinational, depends on state only).
  - Handshake = prod_valid & prod_ready. On handshake: acc <= acc + zero-extended prod, count <= count-1, overflow <= overflow | carry-out.
  - On handshake with count==1: go to DONE; result <= final sum.
  - No handshake: hold all state. Gaps in prod_valid are allowed at any point.
  - Sustains one product per cycle with no bubbles.
- DONE:
  - res_valid=1; result and overflow held stable while res_ready=0.
  - res_valid & res_ready: go to IDLE, res_valid drops the next cycle. result and overflow keep their last values until the next start.
- Latency: res_valid is asserted in the cycle after the last product handshake.
- Minimum gap between results: IDLE re-entry costs one cycle, so start is seen at the earliest in the cycle after the result handshake.
- start while busy (ACCUM or DONE): ignored, with no effect on the current accumulation.
- len is captured only at start; later changes have no effect.
- Arithmetic:
  - Unsigned only.
  - Wraps modulo 2^ACC_W.
  - overflow is sticky for the current accumulation and cleared at the next accepted start.
- Reset mid-ACCUM or mid-DONE: the accumulation is abandoned with no result. After deassertion the block is in IDLE and needs a fresh start.

Test Plan:
- start, len=3; products 0x0001, 0x0002, 0x0003 on consecutive cycles -> res_valid one cycle after third handshake; result=0x000006; overflow=0.
- len=255; 255 products of 0xFE01 (255*255), back-to-back -> result=0xFD02FF; overflow=0; exactly 255 handshakes accepted.
- ACC_W=16; len=2; products 0xFE01, 0xFE01 -> result=0xFC02; overflow=1. A new start with len=1, prod 0x0005 -> result=0x0005; overflow=0.
- len=0 start -> no prod_ready asserted; res_valid the next cycle with result=0.
- len=4, prod_valid toggled with random gaps; res_ready held low 5 cycles in DONE; start pulsed during ACCUM and DONE -> sum correct; result/res_valid stable during stall; extra starts ignored.
- Assert rst after 2 of 4 products -> immediately IDLE, all outputs 0. New start, len=1, prod 0x0007 -> result=0x000007.
